// File: rtl/cb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cb_core_sequencer
// Brief    : Boots the selected cores, waits for sleep or timeout, then
//            signals software completion back to the controller.
// Revision : 1.0
// ============================================================================
module cb_core_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned SLEEP_STABLE   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] boot_addr_i,
    input  logic [2:0]  master_core_i,
    input  logic        safe_mode_i,
    input  logic [1:0]  safe_configuration_i,
    input  logic        critical_section_i,
    input  logic [2:0]  core_sleep_i,
    output logic [2:0]  core_fetch_en_o,
    output logic [31:0] core_boot_addr_o,
    output logic        busy_o,
    output logic        end_sw_o,
    output logic        timeout_o,
    output logic        cfg_err_o
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SCNT_W = 8;

    localparam logic [TCNT_W-1:0] C_TMAX = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [SCNT_W-1:0] C_SMAX = SCNT_W'(SLEEP_STABLE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BOOT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic              start_q;
    logic [2:0]        mask_q,    mask_d;
    logic [31:0]       addr_q,    addr_d;
    logic [TCNT_W-1:0] tcnt_q,    tcnt_d;
    logic [SCNT_W-1:0] scnt_q,    scnt_d;
    logic              timeout_q, timeout_d;
    logic              cfg_err_q, cfg_err_d;

    logic       start_edge;
    logic       master_onehot;
    logic [2:0] master_rot;
    logic [2:0] active_mask;
    logic       sleep_match;
    logic       sleep_done;
    logic       time_done;

    assign start_edge    = start_i & ~start_q;
    assign master_onehot = (master_core_i != 3'b000) &&
                           ((master_core_i & (master_core_i - 3'd1)) == 3'b000);
    assign master_rot    = {master_core_i[1:0], master_core_i[2]};

    always_comb begin
        active_mask = master_core_i;
        if (safe_mode_i) begin
            unique case (safe_configuration_i)
                2'b00:   active_mask = 3'b111;
                2'b01:   active_mask = master_core_i | master_rot;
                default: active_mask = master_core_i;
            endcase
        end
    end

    // Completion conditions look one count ahead so the exit happens in the
    // cycle the threshold is reached, not one cycle later.
    assign sleep_match = ((core_sleep_i & mask_q) == mask_q);
    assign sleep_done  = (state_q == S_RUN) && sleep_match &&
                         ((scnt_q + SCNT_W'(1)) == C_SMAX);
    assign time_done   = (state_q == S_RUN) && !critical_section_i &&
                         ((tcnt_q + TCNT_W'(1)) == C_TMAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b1;
            mask_q    <= 3'b000;
            addr_q    <= 32'd0;
            tcnt_q    <= '0;
            scnt_q    <= '0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_i;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            tcnt_q    <= tcnt_d;
            scnt_q    <= scnt_d;
            timeout_q <= timeout_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_edge && master_onehot) state_d = S_BOOT;
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (sleep_done || time_done) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mask_d    = mask_q;
        addr_d    = addr_q;
        tcnt_d    = tcnt_q;
        scnt_d    = scnt_q;
        timeout_d = timeout_q;
        cfg_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                scnt_d = '0;
                if (start_edge) begin
                    if (master_onehot) begin
                        mask_d    = active_mask;
                        addr_d    = boot_addr_i;
                        timeout_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_BOOT: begin
                tcnt_d = '0;
                scnt_d = '0;
            end
            S_RUN: begin
                if (sleep_match) begin
                    if (scnt_q != C_SMAX) scnt_d = scnt_q + SCNT_W'(1);
                end else begin
                    scnt_d = '0;
                end
                if (!critical_section_i && (tcnt_q != C_TMAX)) begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
                // Sleep completion wins a same-cycle race with the timeout.
                if (time_done && !sleep_done) timeout_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        core_fetch_en_o  = (state_q == S_RUN) ? mask_q : 3'b000;
        core_boot_addr_o = addr_q;
        busy_o           = (state_q != S_IDLE);
        end_sw_o         = (state_q == S_DONE);
        timeout_o        = timeout_q;
        cfg_err_o        = cfg_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cb_core_sequencer
// Brief    : Self-checking bench: run table with completion scoreboard plus
//            hand sequences for reset, rejection and ignored starts.
// Revision : 1.0
// ============================================================================
module tb_cb_core_sequencer;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] boot_addr_i;
    logic [2:0]  master_core_i;
    logic        safe_mode_i;
    logic [1:0]  safe_configuration_i;
    logic        critical_section_i;
    logic [2:0]  core_sleep_i;
    logic [2:0]  core_fetch_en_o;
    logic [31:0] core_boot_addr_o;
    logic        busy_o;
    logic        end_sw_o;
    logic        timeout_o;
    logic        cfg_err_o;

    cb_core_sequencer #(
        .TIMEOUT_CYCLES(8),
        .SLEEP_STABLE  (4)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .start_i             (start_i),
        .boot_addr_i         (boot_addr_i),
        .master_core_i       (master_core_i),
        .safe_mode_i         (safe_mode_i),
        .safe_configuration_i(safe_configuration_i),
        .critical_section_i  (critical_section_i),
        .core_sleep_i        (core_sleep_i),
        .core_fetch_en_o     (core_fetch_en_o),
        .core_boot_addr_o    (core_boot_addr_o),
        .busy_o              (busy_o),
        .end_sw_o            (end_sw_o),
        .timeout_o           (timeout_o),
        .cfg_err_o           (cfg_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // sleep_pat is driven on RUN cycle n when n > sleep_delay and n != sleep_gap;
    // critical_section_i is high on RUN cycles 1..crit_cycles.
    typedef struct {
        logic        sm;
        logic [1:0]  cfg;
        logic [2:0]  master;
        logic [31:0] addr;
        logic [2:0]  sleep_pat;
        int          sleep_delay;
        int          sleep_gap;
        int          crit_cycles;
        logic [2:0]  exp_fetch;
        int          exp_runs;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs[10];
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " fetch_en"},  {29'd0, core_fetch_en_o}, 32'd0);
        check({tag, " boot_addr"}, core_boot_addr_o, 32'd0);
        check({tag, " busy"},      {31'd0, busy_o}, 32'd0);
        check({tag, " end_sw"},    {31'd0, end_sw_o}, 32'd0);
        check({tag, " timeout"},   {31'd0, timeout_o}, 32'd0);
        check({tag, " cfg_err"},   {31'd0, cfg_err_o}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t       e;
        int         steps;
        int         runs;
        int         lat;
        logic [2:0] fseen;
        logic       done;
        sb_q.push_back(v);
        safe_mode_i          = v.sm;
        safe_configuration_i = v.cfg;
        master_core_i        = v.master;
        boot_addr_i          = v.addr;
        core_sleep_i         = 3'b000;
        critical_section_i   = 1'b0;
        start_i              = 1'b1;
        step();
        steps = 1;
        check("boot busy",    {31'd0, busy_o}, 32'd1);
        check("boot fetch",   {29'd0, core_fetch_en_o}, 32'd0);
        check("boot addr",    core_boot_addr_o, v.addr);
        check("boot timeout", {31'd0, timeout_o}, 32'd0);
        runs = 0; lat = 0; fseen = 3'b000; done = 1'b0;
        for (int g = 0; g < 64 && !done; g++) begin
            step();
            steps++;
            if (end_sw_o) begin
                done = 1'b1;
            end else if (core_fetch_en_o != 3'b000) begin
                runs++;
                if (runs == 1) begin
                    lat   = steps;
                    fseen = core_fetch_en_o;
                end
                core_sleep_i = (runs > v.sleep_delay && runs != v.sleep_gap) ? v.sleep_pat : 3'b000;
                critical_section_i = (runs <= v.crit_cycles);
            end
        end
        start_i            = 1'b0;
        core_sleep_i       = 3'b000;
        critical_section_i = 1'b0;
        check("run completed", {31'd0, done}, 32'd1);
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            check("fetch mask",     {29'd0, fseen}, {29'd0, e.exp_fetch});
            check("fetch latency",  lat, 2);
            check("run cycles",     runs, e.exp_runs);
            check("done timeout",   {31'd0, timeout_o}, {31'd0, e.exp_timeout});
            check("done fetch off", {29'd0, core_fetch_en_o}, 32'd0);
            step();
            check("end_sw single",  {31'd0, end_sw_o}, 32'd0);
            check("idle busy",      {31'd0, busy_o}, 32'd0);
            check("idle addr hold", core_boot_addr_o, e.addr);
            check("idle timeout",   {31'd0, timeout_o}, {31'd0, e.exp_timeout});
        end
        if (!done) begin
            rst_ni = 1'b0;
            step();
            rst_ni = 1'b1;
            step();
        end
    endtask

    initial begin
        //             sm    cfg    master  addr          pat     dly gap crit  fetch   runs to
        vecs[0] = '{1'b0, 2'b00, 3'b010, 32'h0000_1000, 3'b010, 0, 0, 0,  3'b010, 4,  1'b0};
        vecs[1] = '{1'b1, 2'b01, 3'b100, 32'h0000_2000, 3'b100, 0, 0, 0,  3'b101, 8,  1'b1};
        vecs[2] = '{1'b1, 2'b01, 3'b100, 32'h0000_2004, 3'b101, 1, 0, 0,  3'b101, 5,  1'b0};
        vecs[3] = '{1'b1, 2'b00, 3'b001, 32'h0000_3000, 3'b111, 2, 0, 0,  3'b111, 6,  1'b0};
        vecs[4] = '{1'b1, 2'b10, 3'b001, 32'h0000_4000, 3'b001, 0, 0, 0,  3'b001, 4,  1'b0};
        vecs[5] = '{1'b1, 2'b11, 3'b100, 32'h0000_5000, 3'b111, 0, 0, 0,  3'b100, 4,  1'b0};
        vecs[6] = '{1'b1, 2'b01, 3'b001, 32'h0000_6000, 3'b011, 3, 0, 0,  3'b011, 7,  1'b0};
        vecs[7] = '{1'b0, 2'b00, 3'b001, 32'h0000_7000, 3'b000, 0, 0, 5,  3'b001, 13, 1'b1};
        vecs[8] = '{1'b0, 2'b01, 3'b010, 32'h0000_8000, 3'b010, 4, 0, 0,  3'b010, 8,  1'b0};
        vecs[9] = '{1'b1, 2'b01, 3'b010, 32'h0000_9000, 3'b110, 0, 4, 20, 3'b110, 8,  1'b0};

        rst_ni = 1'b0; start_i = 1'b0; boot_addr_i = 32'd0; master_core_i = 3'b000;
        safe_mode_i = 1'b0; safe_configuration_i = 2'b00;
        critical_section_i = 1'b0; core_sleep_i = 3'b000;
        #3;
        check_reset_outputs("reset");
        step();
        step();
        rst_ni = 1'b1;
        step();
        check("post reset busy", {31'd0, busy_o}, 32'd0);

        // Multi-hot and zero masks are rejected with a single pulse.
        master_core_i = 3'b011;
        boot_addr_i   = 32'hDEAD_0000;
        start_i       = 1'b1;
        step();
        check("cfg_err pulse",   {31'd0, cfg_err_o}, 32'd1);
        check("cfg_err busy",    {31'd0, busy_o}, 32'd0);
        check("cfg_err addr",    core_boot_addr_o, 32'd0);
        step();
        check("cfg_err cleared", {31'd0, cfg_err_o}, 32'd0);
        check("cfg_err fetch",   {29'd0, core_fetch_en_o}, 32'd0);
        start_i = 1'b0;
        master_core_i = 3'b000;
        step();
        start_i = 1'b1;
        step();
        check("cfg_err zero mask", {31'd0, cfg_err_o}, 32'd1);
        start_i = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Start edge mid-run is ignored, then reset lands in RUN.
        safe_mode_i = 1'b0; master_core_i = 3'b001; boot_addr_i = 32'hA000_0000;
        critical_section_i = 1'b1; start_i = 1'b1;
        step();
        step();
        check("midrun fetch", {29'd0, core_fetch_en_o}, 32'd1);
        start_i = 1'b0;
        step();
        start_i = 1'b1; master_core_i = 3'b011; boot_addr_i = 32'hB000_0000;
        step();
        check("ignored cfg_err", {31'd0, cfg_err_o}, 32'd0);
        check("ignored addr",    core_boot_addr_o, 32'hA000_0000);
        check("ignored fetch",   {29'd0, core_fetch_en_o}, 32'd1);
        check("ignored busy",    {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async reset");

        // start_i stays high through reset release with a legal config.
        master_core_i = 3'b001;
        critical_section_i = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
        step();
        step();
        check("held start busy",    {31'd0, busy_o}, 32'd0);
        check("held start fetch",   {29'd0, core_fetch_en_o}, 32'd0);
        check("held start cfg_err", {31'd0, cfg_err_o}, 32'd0);
        start_i = 1'b0;
        step();
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cb_core_sequencer.md
CB_CORE_SEQUENCER -- requirements
Module: cb_core_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: number of non-critical RUN cycles before forced completion; legal range 2..2^20.
REQ-002 Parameter SLEEP_STABLE, default 4: consecutive cycles all active cores must report sleep before completion; legal range 1..255.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  level start request from cb_heep_ctrl Start_o; acted on at its 0->1 edge only.
REQ-006 boot_addr_i  in  32  boot address, sampled on the accepted start edge.
REQ-007 master_core_i  in  3  one-hot master core select, sampled on the accepted start edge.
REQ-008 safe_mode_i  in  1  lockstep mode enable, sampled on the accepted start edge.
REQ-009 safe_configuration_i  in  2  lockstep configuration, sampled on the accepted start edge.
REQ-010 critical_section_i  in  1  live level; freezes the timeout counter while high.
REQ-011 core_sleep_i  in  3  per-core sleep/WFI indication, bit n = core n.
REQ-012 core_fetch_en_o  out  3  per-core fetch enable.
REQ-013 core_boot_addr_o  out  32  boot address presented to all cores.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 end_sw_o  out  1  one-cycle completion pulse to cb_heep_ctrl EndSw_i.
REQ-016 timeout_o  out  1  sticky flag: last run ended by timeout.
REQ-017 cfg_err_o  out  1  one-cycle pulse: start edge rejected due to bad master_core_i.

Function
REQ-018 The block SHALL register start_i and detect a rising edge as start_i=1 and previous sample=0; the previous sample SHALL reset to 1, so a start_i held high through reset does not trigger a run.
REQ-019 Active mask SHALL be computed at the accepted edge: safe_mode_i=0 -> master_core_i; safe_mode_i=1 with config 2'b00 -> 3'b111; config 2'b01 -> master_core_i OR master_core_i rotated left by 1 (3-bit wrap, e.g. 3'b100 -> 3'b101); config 2'b10/2'b11 -> master_core_i.
REQ-020 FSM states SHALL be IDLE, BOOT, RUN, DONE.
REQ-021 IDLE: on a start edge with master_core_i one-hot, latch mask and boot_addr_i, clear timeout_o, go to BOOT; with master_core_i zero or multi-hot, pulse cfg_err_o for one cycle and stay in IDLE.
REQ-022 Start edges outside IDLE SHALL be ignored (no latch, no cfg_err_o).
REQ-023 BOOT: core_boot_addr_o SHALL already show the latched address; fetch_en stays 0; after exactly one cycle go to RUN.
REQ-024 RUN: core_fetch_en_o SHALL equal the latched mask; inactive cores SHALL have fetch_en 0.
REQ-025 RUN: the stable counter SHALL increment each cycle in which (core_sleep_i & mask) == mask, and clear to 0 on any cycle in which it does not; reaching SLEEP_STABLE SHALL go to DONE.
REQ-026 RUN: the timeout counter SHALL increment each cycle with critical_section_i=0 and hold when it is 1; reaching TIMEOUT_CYCLES SHALL set timeout_o and go to DONE.
REQ-027 If sleep-stable completion and timeout occur in the same cycle, sleep completion SHALL win and timeout_o SHALL remain 0.
REQ-028 DONE: core_fetch_en_o SHALL be 0, end_sw_o SHALL be 1 for this single cycle, and the next state SHALL be IDLE.
REQ-029 Latency: first fetch_en=1 SHALL occur 2 cycles after the cycle in which the start edge is sampled; end_sw_o SHALL occur 1 cycle after the completing RUN cycle.
REQ-030 Both counters SHALL be cleared on entry to RUN and SHALL saturate and never wrap.
REQ-031 core_boot_addr_o SHALL hold its last latched value in IDLE.

Reset
REQ-032 On rst_ni=0, at any time including mid-run, the block SHALL enter IDLE immediately, with core_fetch_en_o=0, core_boot_addr_o=0, busy_o=0, end_sw_o=0, timeout_o=0, cfg_err_o=0, mask=0, counters=0, and start history=1.

Verification
REQ-033 safe_mode=0, master=3'b010, addr=0x0000_1000, start 0->1 -> fetch_en=3'b010 two cycles later; core_sleep_i=3'b010 for 4 cycles -> end_sw_o pulses once; fetch_en=0; timeout_o=0.
REQ-034 safe_mode=1, config=2'b01, master=3'b100 -> fetch_en=3'b101; sleep=3'b100 only -> no completion; sleep=3'b101 for 4 cycles -> end_sw_o.
REQ-035 TIMEOUT_CYCLES=8, no sleep, critical_section_i high for 5 RUN cycles -> end_sw_o after 13 RUN cycles and timeout_o=1; next accepted start clears it.
REQ-036 master=3'b011 with start edge -> cfg_err_o single pulse; busy_o stays 0; fetch_en stays 0.
REQ-037 start_i held high across reset release -> no run; rst_ni asserted in RUN -> all outputs at reset values in the same cycle.
REQ-038 sleep toggles off in the cycle before reaching SLEEP_STABLE -> stable counter restarts; completion is delayed by the full SLEEP_STABLE count.
